// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, field bit positions
// and the exception handler entry point.
package cp0_pkg;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int SR_IM_HI     = 15;
   localparam int SR_IM_LO     = 10;
   localparam int SR_EXL       = 1;
   localparam int SR_IE        = 0;
   localparam int CAUSE_BD     = 31;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_EXC_LO = 2;

   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_unit.sv
// M-stage coprocessor-0: decides interrupt/exception entry, drives the global
// flush request and holds SR, Cause and EPC for mtc0/mfc0/eret.
module cp0_unit #(
   parameter logic [31:0] HANDLER_ADDR = cp0_pkg::HANDLER_ADDR,
   parameter logic [31:0] PRID_VALUE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] VPC,
   input  logic        BD_M,
   input  logic [4:0]  ExcCode_M,
   input  logic        EXLClr,
   input  logic [5:0]  HWInt,
   output logic        Req,
   output logic [31:0] DOut,
   output logic [31:0] EPCOut
);
   import cp0_pkg::*;

   logic [5:0]  sr_im_reg;
   logic        sr_exl_reg;
   logic        sr_ie_reg;
   logic        cause_bd_reg;
   logic [5:0]  cause_ip_reg;
   logic [4:0]  cause_exc_reg;
   logic [31:0] epc_reg;

   logic        int_req;
   logic        exc_req;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   assign int_req = (|(HWInt & sr_im_reg)) & sr_ie_reg & ~sr_exl_reg;
   assign exc_req = (ExcCode_M != EXC_INT) & ~sr_exl_reg;
   assign Req     = int_req | exc_req;

   assign sr_word    = {16'b0, sr_im_reg, 8'b0, sr_exl_reg, sr_ie_reg};
   assign cause_word = {cause_bd_reg, 15'b0, cause_ip_reg, 3'b0, cause_exc_reg, 2'b0};

   // Forward an in-flight mtc0 EPC so an eret in D jumps to the new value.
   assign EPCOut = (WE && A2 == REG_EPC) ? DIn : epc_reg;

   always_comb begin
      DOut = 32'h0;
      case (A1)
         REG_SR:    DOut = sr_word;
         REG_CAUSE: DOut = cause_word;
         REG_EPC:   DOut = epc_reg;
         REG_PRID:  DOut = PRID_VALUE;
         default:   DOut = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im_reg     <= 6'b0;
         sr_exl_reg    <= 1'b0;
         sr_ie_reg     <= 1'b0;
         cause_bd_reg  <= 1'b0;
         cause_ip_reg  <= 6'b0;
         cause_exc_reg <= 5'b0;
         epc_reg       <= 32'h0;
      end else begin
         cause_ip_reg <= HWInt;
         if (Req) begin
            // Interrupt wins over a simultaneous synchronous exception.
            sr_exl_reg    <= 1'b1;
            cause_exc_reg <= int_req ? EXC_INT : ExcCode_M;
            cause_bd_reg  <= BD_M;
            epc_reg       <= BD_M ? (VPC - 32'd4) : VPC;
         end else begin
            if (WE && A2 == REG_SR) begin
               sr_im_reg  <= DIn[SR_IM_HI:SR_IM_LO];
               sr_exl_reg <= DIn[SR_EXL];
               sr_ie_reg  <= DIn[SR_IE];
            end
            if (WE && A2 == REG_EPC)
               epc_reg <= DIn;
            if (EXLClr)
               sr_exl_reg <= 1'b0;
         end
      end
   end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 exception/interrupt controller at the M stage. It consumes the per-instruction exception code, branch-delay flag and PC carried down the pipeline registers, together with external hardware interrupt lines. It then decides whether the M-stage instruction is interrupted. It drives the single global `Req` that flushes every pipeline register and redirects fetch to the handler at 0x0000_4180. It also holds SR, Cause and EPC for `mtc0`, `mfc0` and `eret`.

## Interface
Parameters:
- `HANDLER_ADDR`, 32'h0000_4180: handler entry, exported for the fetch mux.
- `PRID_VALUE`, 32'h0000_0000: constant returned for PRId reads.

Ports (reset: reset, synchronous, active-high; clock clk):
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `A1`  in  5  `mfc0` source register number
- `A2`  in  5  `mtc0` destination register number
- `DIn`  in  32  `mtc0` write data
- `WE`  in  1  `mtc0` in M stage
- `VPC`  in  32  PC of the M-stage instruction
- `BD_M`  in  1  M-stage instruction sits in a delay slot
- `ExcCode_M`  in  5  exception code of the M-stage instruction; 0 means none
- `EXLClr`  in  1  `eret` in M stage
- `HWInt`  in  6  external interrupt lines, level-sensitive
- `Req`  out  1  flush/redirect request, combinational
- `DOut`  out  32  `mfc0` read data, combinational
- `EPCOut`  out  32  `eret` target, with bypass

## Operation
- **SR (12):** bits IM[15:10], EXL[1] and IE[0] are stored. All other bits read 0.
- **Cause (13):** bits BD[31], IP[15:10] and ExcCode[6:2] are stored. Software cannot write Cause.
- **EPC (14):** full 32 bits, writable.
- **PRId (15):** returns `PRID_VALUE`. Read-only.
- **Other register numbers:** read 0; writes are ignored.
- `IntReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL`.
- `ExcReq = (ExcCode_M != 0) & ~SR.EXL`.
- `Req = IntReq | ExcReq`.
- Priority: an interrupt beats a synchronous exception. If both are pending, the recorded ExcCode is 0 (Int).
- On an edge with `Req` set:
  - SR.EXL <= 1
  - Cause.ExcCode <= `IntReq` ? 0 : `ExcCode_M`
  - Cause.BD <= `BD_M`
  - EPC <= `BD_M` ? `VPC`-4 : `VPC`
- Cause.IP <= `HWInt` on every non-reset edge, independent of `Req`.
- `mtc0` (`WE` and not `Req`) writes SR or EPC at the edge. `Req` suppresses the write.
- `EXLClr` and not `Req` clears SR.EXL at the edge. `EXLClr` with EXL already 0 has no effect.
- `DOut` returns the register contents before any same-cycle write.
- `EPCOut` equals `DIn` when `WE` and `A2`==14; otherwise it equals EPC. This lets `eret` in D see an `mtc0 EPC` that is in M.

## Timing
- **Reset:** SR, Cause and EPC all clear to 0. `Req` is therefore 0 unless `ExcCode_M`≠0; the pipeline registers also reset, so that code is 0 too. `DOut` and `EPCOut` read 0 until written.
- `Req`, `DOut` and `EPCOut` have zero latency (combinational).
- All register updates take effect at the next posedge.
- While EXL=1, `Req` is held low:
  - no nested exceptions or interrupts;
  - `ExcCode_M` is ignored.
- `Req` with `reset`: reset wins and no state is recorded.
- `Req` with `EXLClr`: cannot both be effective, because `Req` needs EXL=0. If it occurs, the `Req` update takes effect.
- `Req` with `WE`: the exception update takes effect and the `mtc0` is dropped. The flushed instruction re-executes after `eret`.
- `VPC` of a bubble (flushed stage) is 0 or 0x4180 with `ExcCode_M`=0 and `BD_M`=0, so an interrupt taken on a bubble records that PC. The pipeline is responsible for presenting the true PC of the next instruction on bubbles; this block does not track it.

## Structure
- Shared package `cp0_pkg`:
  - register numbers SR=12, CAUSE=13, EPC=14, PRID=15;
  - ExcCodes Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
  - bit positions of IM, EXL, IE, BD, IP and ExcCode;
  - `HANDLER_ADDR`.
- Single module. No sub-module is warranted.

## Test plan
1. SR=0x0000_0401 (IM[10]=1, IE=1), pulse `HWInt`=6'b000001 with `VPC`=0x3010 and `BD_M`=0 → `Req`=1 that cycle. Next cycle: EPC=0x3010, Cause.ExcCode=0, EXL=1, `Req`=0.
2. `ExcCode_M`=12 (Ov), `BD_M`=1, `VPC`=0x3024 → `Req`=1, then EPC=0x3020, Cause=0x8000_0030 (BD=1, IP=0).
3. Same cycle: pending unmasked interrupt and `ExcCode_M`=4 → ExcCode recorded as 0.
4. `WE`=1, `A2`=14, `DIn`=0x3100, plus `Req` via `ExcCode_M`=10 → EPC=`VPC`, not 0x3100. Repeat without `Req` → EPC=0x3100, and `EPCOut`=0x3100 during the write cycle.
5. EXL=1 and `ExcCode_M`=12 → `Req`=0. Then `EXLClr`=1 → EXL=0 next cycle, and a pending masked-in interrupt raises `Req` one cycle later.
6. Reset mid-handler (EXL=1, EPC=0x3010) → all registers 0, `DOut`=0 for `A1`=12/13/14, `DOut`=`PRID_VALUE` for `A1`=15, and `DOut`=0 for `A1`=7.
